// File: rtl/reg_wb_arbiter_if.sv
// Write-back arbiter bus: requester handshake plus register-file strobe/data.
// slave = arbiter side, master = requester / register-file side.
interface reg_wb_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WORD  = 32,
    parameter int RADDR = 5
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ*RADDR-1:0] req_addr_i;
    logic [N_REQ*WORD-1:0]  req_data_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic                   wb_stall_i;
    logic [2**RADDR-1:0]    wb_o;
    logic [WORD-1:0]        wb_data_o;
    logic [SRC_W-1:0]       wb_src_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, wb_stall_i,
        output req_ready_o, wb_o, wb_data_o, wb_src_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_data_i, wb_stall_i,
        input  req_ready_o, wb_o, wb_data_o, wb_src_o
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin write-back arbiter: one registered write per cycle, one-hot strobe.
// Optional WB_ZERO_SKIP_EN: accept writes to register 0 but never strobe them.
module reg_wb_arbiter #(
    parameter int N_REQ = 4,
    parameter int WORD  = 32,
    parameter int RADDR = 5
) (
    input logic            clk,
    input logic            rst,
    reg_wb_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(N_REQ);
    localparam logic [SRC_W:0]   NREQ_W = (SRC_W+1)'(N_REQ);
    localparam logic [SRC_W-1:0] LAST   = SRC_W'(N_REQ - 1);

    logic [RADDR-1:0] addr_arr [N_REQ];
    logic [WORD-1:0]  data_arr [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign addr_arr[k] = bus.req_addr_i[k*RADDR +: RADDR];
        assign data_arr[k] = bus.req_data_i[k*WORD +: WORD];
    end

    logic [SRC_W-1:0] rr_q, rr_d;
    logic             out_valid_q, out_valid_d;
    logic [RADDR-1:0] out_addr_q, out_addr_d;
    logic [WORD-1:0]  out_data_q, out_data_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;

    logic             grant_any;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W:0]   cand;
    logic [N_REQ-1:0] ready;
    logic [2**RADDR-1:0] wb;

    // Scan from rr_q upward with modulo wrap; the extra bit avoids overflow for any N_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        ready     = '0;
        if (!rst && !bus.wb_stall_i) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cand = {1'b0, rr_q} + (SRC_W+1)'(i);
                if (cand >= NREQ_W) cand = cand - NREQ_W;
                if (!grant_any && bus.req_valid_i[cand[SRC_W-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = cand[SRC_W-1:0];
                end
            end
            if (grant_any) ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (!bus.wb_stall_i) begin
            out_valid_d = 1'b0;
            if (grant_any) begin
`ifdef WB_ZERO_SKIP_EN
                out_valid_d = (addr_arr[grant_idx] != '0);
`else
                out_valid_d = 1'b1;
`endif
                out_addr_d = addr_arr[grant_idx];
                out_data_d = data_arr[grant_idx];
                out_src_d  = grant_idx;
                rr_d       = (grant_idx == LAST) ? '0 : grant_idx + SRC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    always_comb begin
        wb = '0;
        if (out_valid_q) wb[out_addr_q] = 1'b1;
    end

    assign bus.req_ready_o = ready;
    assign bus.wb_o        = wb;
    assign bus.wb_data_o   = out_data_q;
    assign bus.wb_src_o    = out_src_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios then random traffic against a
// cycle-level model of grant order and the presented write.
module tb_reg_wb_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    localparam int R = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_wb_arbiter_if #(.N_REQ(N), .WORD(W), .RADDR(R)) bus ();

    reg_wb_arbiter #(.N_REQ(N), .WORD(W), .RADDR(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // model state
    int          m_rr    = 0;
    bit          m_valid = 1'b0;
    int unsigned m_addr  = 0;
    logic [W-1:0] m_data = '0;
    int          m_src   = 0;

    // DUT outputs sampled in the last cycle
    logic [N-1:0]  last_ready;
    logic [31:0]   last_wb;
    logic [W-1:0]  last_data;
    logic [1:0]    last_src;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        if (rst || bus.wb_stall_i) return -1;
        for (int i = 0; i < N; i++) begin
            int u = (m_rr + i) % N;
            if (bus.req_valid_i[u]) return u;
        end
        return -1;
    endfunction

    task automatic set_req(input int u, input bit v, input logic [R-1:0] a, input logic [W-1:0] d);
        bus.req_valid_i[u]         = v;
        bus.req_addr_i[u*R +: R]   = a;
        bus.req_data_i[u*W +: W]   = d;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic cycle();
        int g;
        logic [N-1:0] er;
        logic [31:0] ewb;
        logic [N*R-1:0] av;
        logic [N*W-1:0] dv;
        #3;
        g  = exp_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        ewb = m_valid ? (32'd1 << m_addr) : 32'd0;
        last_ready = bus.req_ready_o;
        last_wb    = bus.wb_o;
        last_data  = bus.wb_data_o;
        last_src   = bus.wb_src_o;
        check("ready", last_ready, er);
        check("wb_o", last_wb, ewb);
        check("wb_data", last_data, m_data);
        check("wb_src", last_src, m_src);
        av = bus.req_addr_i;
        dv = bus.req_data_i;
        @(posedge clk);
        #1;
        if (rst) begin
            m_rr = 0; m_valid = 0; m_addr = 0; m_data = '0; m_src = 0;
        end else if (!bus.wb_stall_i) begin
            if (g >= 0) begin
                m_addr = int'((av >> (g*R)) & ((1 << R) - 1));
                m_data = W'(dv >> (g*W));
                m_src  = g;
                m_rr   = (g + 1) % N;
`ifdef WB_ZERO_SKIP_EN
                m_valid = (m_addr != 0);
`else
                m_valid = 1'b1;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    logic [N-1:0]   prev_valid;
    logic [N*R-1:0] prev_addr;
    logic [N*W-1:0] prev_data;

    initial begin
        bus.req_valid_i = '0;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;
        bus.wb_stall_i  = 1'b0;
        @(posedge clk);
        #1;

        // reset held with every unit requesting; addresses 1..4 for the round-robin run
        for (int u = 0; u < N; u++) set_req(u, 1'b1, R'(u + 1), W'(32'hA000_0000 + u));
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("rst_ready0", last_ready, 0);
            check("rst_wb0", last_wb, 0);
        end
        rst = 1'b0;

        // round robin: grants 0,1,2,3,0 with strobes one cycle later
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("rr_grant", last_ready, 64'd1 << (k % N));
            if (k >= 1) check("rr_strobe", last_wb, 64'd1 << ((k - 1) % N + 1));
        end
        bus.req_valid_i = '0;
        cycle();
        check("rr_strobe_last", last_wb, 64'd1 << 1);

        // single request from unit 2
        set_req(2, 1'b1, 5'd7, 32'hDEADBEEF);
        cycle();
        check("single_ready", last_ready, 4'b0100);
        bus.req_valid_i = '0;
        cycle();
        check("single_wb", last_wb, 64'd1 << 7);
        check("single_data", last_data, 32'hDEADBEEF);
        check("single_src", last_src, 2);
        cycle();
        check("single_idle", last_wb, 0);

        // stall: unit 1 accepted, then three stalled cycles with unit 3 waiting
        set_req(1, 1'b1, 5'd9, 32'h1111_2222);
        cycle();
        check("stall_acc", last_ready, 4'b0010);
        bus.req_valid_i = '0;
        set_req(3, 1'b1, 5'd11, 32'h3333_4444);
        bus.wb_stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("stall_ready", last_ready, 0);
            check("stall_wb", last_wb, 64'd1 << 9);
        end
        bus.wb_stall_i = 1'b0;
        cycle();
        check("stall_release", last_ready, 4'b1000);
        bus.req_valid_i = '0;
        cycle();
        check("stall_present", last_wb, 64'd1 << 11);
        check("stall_src", last_src, 3);

        // reset in the cycle after an accept
        set_req(0, 1'b1, 5'd5, 32'h5555_0000);
        cycle();
        bus.req_valid_i = '0;
        rst = 1'b1;
        cycle();
        check("midrst_present", last_wb, 64'd1 << 5);
        rst = 1'b0;
        for (int u = 0; u < N; u++) set_req(u, 1'b1, R'(u + 20), W'(32'hB000_0000 + u));
        cycle();
        check("midrst_wb", last_wb, 0);
        check("midrst_rr0", last_ready, 4'b0001);
        bus.req_valid_i = '0;
        cycle();

        // write to register 0 from unit 0, then everyone requests
        set_req(0, 1'b1, 5'd0, 32'h12345678);
        cycle();
        check("zero_ready", last_ready, 4'b0001);
        bus.req_valid_i = '1;
        cycle();
`ifdef WB_ZERO_SKIP_EN
        check("zero_wb", last_wb, 0);
`else
        check("zero_wb", last_wb, 1);
        check("zero_data", last_data, 32'h12345678);
`endif
        check("zero_next", last_ready, 4'b0010);
        bus.req_valid_i = '0;
        cycle();

        // random traffic: requesters hold until they see ready
        last_ready = '0;
        for (int c = 0; c < 400; c++) begin
            bit ok;
            for (int u = 0; u < N; u++) begin
                if (bus.req_valid_i[u] && last_ready[u]) bus.req_valid_i[u] = 1'b0;
                if (!bus.req_valid_i[u] && $urandom_range(2) == 0)
                    set_req(u, 1'b1, R'($urandom), W'($urandom));
            end
            if (c > 0) begin
                ok = 1'b1;
                for (int u = 0; u < N; u++)
                    if (prev_valid[u] && !last_ready[u])
                        if (!bus.req_valid_i[u] ||
                            bus.req_addr_i[u*R +: R] !== prev_addr[u*R +: R] ||
                            bus.req_data_i[u*W +: W] !== prev_data[u*W +: W])
                            ok = 1'b0;
                check("req_hold", ok, 1);
            end
            bus.wb_stall_i = ($urandom_range(4) == 0);
            rst = ($urandom_range(59) == 0);
            prev_valid = bus.req_valid_i;
            prev_addr  = bus.req_addr_i;
            prev_data  = bus.req_data_i;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
